// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared constants for the interrupt controller: register-port word indices,
// the bit position of the overflow field inside STATUS/CLEAR, and the default
// number of interrupt sources (the CPU core's interrupt width).
// -----------------------------------------------------------------------------
package irq_pkg;

  // Default source count; must match the core's `interrupts` width.
  localparam int IRQ_NSRC = 4;

  // Register-port word indices (bus_addr).
  localparam int REG_STATUS = 0;  // read-only, pending (+ overflow when enabled)
  localparam int REG_MASK   = 1;  // read/write enable per source
  localparam int REG_CLEAR  = 2;  // write-1-to-clear, reads 0
  localparam int REG_MODE   = 3;  // read/write, 1 = level, 0 = edge

  // LSB of the overflow field in STATUS (read) and CLEAR (write).
  localparam int OVF_LSB = 4;

endpackage : irq_pkg

// File: rtl/irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// Vectorised multi-flop synchroniser. Each bit of i_async passes through
// STAGES flip-flops clocked by clk; o_sync is the last stage. STAGES must be
// at least 2 for metastability protection.
//
// Ports:
//   clk      in   1      destination clock
//   rst      in   1      asynchronous, active-low reset
//   i_async  in   WIDTH  signals asynchronous to clk
//   o_sync   out  WIDTH  synchronised copy, STAGES cycles late
// -----------------------------------------------------------------------------
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // NOTE: every synchroniser stage is reset explicitly; this is a short flop
  // chain, not a RAM, so clearing it costs nothing and keeps stale requests
  // from leaking out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule : irq_sync

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Interrupt controller feeding the CPU core's `interrupts` input. Raw
// peripheral requests are synchronised, edge- or level-detected, latched in a
// pending register, gated by a mask and presented to the core. The CPU
// configures and acknowledges it through a 4-word register port:
//   0 STATUS (RO pending), 1 MASK (RW), 2 CLEAR (W1C, reads 0), 3 MODE (RW).
//
// Optional build macro IRQ_OVF_EN: adds a per-source overflow flag, set when
// a new edge arrives while that source is still pending; read in STATUS
// [NSRC+3:4], cleared through CLEAR [NSRC+3:4].
//
// Ports:
//   clk        in   1     system clock
//   rst        in   1     asynchronous, active-low reset
//   irq_raw    in   NSRC  raw request lines, asynchronous to clk
//   bus_sel    in   1     register-port access strobe
//   bus_we     in   1     1 = write, 0 = read (qualified by bus_sel)
//   bus_addr   in   AW    register word index
//   bus_wdata  in   DW    write data
//   bus_rdata  out  DW    read data, registered, holds between reads
//   int_out    out  NSRC  pending & mask, registered
//   int_any    out  1     OR of int_out, registered
//   int_id     out  2     lowest set bit index of int_out (0 when none)
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC        = IRQ_NSRC,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = 2,
  parameter int DW          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_raw,
  input  logic            bus_sel,
  input  logic            bus_we,
  input  logic [AW-1:0]   bus_addr,
  input  logic [DW-1:0]   bus_wdata,
  output logic [DW-1:0]   bus_rdata,
  output logic [NSRC-1:0] int_out,
  output logic            int_any,
  output logic [1:0]      int_id
);

  logic [NSRC-1:0] w_s;             // synchronised requests
  logic [NSRC-1:0] r_s_d;           // w_s delayed one cycle (edge history)
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [DW-1:0]   r_rdata;
  logic [NSRC-1:0] r_int_out;
  logic            r_int_any;
  logic [1:0]      r_int_id;

  logic            w_wr;
  logic            w_rd;
  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pending_next;
  logic [NSRC-1:0] w_mask_next;
  logic [NSRC-1:0] w_mode_next;
  logic [NSRC-1:0] w_int_next;
  logic [1:0]      w_id_next;
  logic [DW-1:0]   w_status;
  logic [DW-1:0]   w_rdata_next;
  logic            w_unused_wdata;

  irq_sync #(
    .WIDTH  (NSRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (irq_raw),
    .o_sync  (w_s)
  );

  assign w_wr = bus_sel &  bus_we;
  assign w_rd = bus_sel & ~bus_we;

  // Edge mode fires on a rising synchronised edge; level mode fires whenever
  // the line is high. r_s_d tracks in both modes, so a mode switch never
  // fabricates an edge.
  assign w_set = w_s & (r_mode | ~r_s_d);
  assign w_clr = (w_wr && bus_addr == AW'(REG_CLEAR)) ? bus_wdata[NSRC-1:0] : '0;

  // Set wins over a simultaneous clear so no request is ever lost.
  assign w_pending_next = w_set | (r_pending & ~w_clr);
  assign w_mask_next    = (w_wr && bus_addr == AW'(REG_MASK)) ? bus_wdata[NSRC-1:0] : r_mask;
  assign w_mode_next    = (w_wr && bus_addr == AW'(REG_MODE)) ? bus_wdata[NSRC-1:0] : r_mode;

  // Outputs are registered from next-state values so int_out always equals
  // the pending & mask that the same edge commits.
  assign w_int_next = w_pending_next & w_mask_next;

  // NOTE: every variable an always_comb writes gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_id_next = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_int_next[i]) w_id_next = 2'(i);
    end
  end

`ifdef IRQ_OVF_EN
  logic [NSRC-1:0] r_ovf;
  logic [NSRC-1:0] w_ovf_set;
  logic [NSRC-1:0] w_ovf_clr;

  // A fresh edge that lands on a still-pending, not-being-cleared source
  // means an interrupt was coalesced; record it.
  assign w_ovf_set = w_set & ~r_mode & r_pending & ~w_clr;
  assign w_ovf_clr = (w_wr && bus_addr == AW'(REG_CLEAR)) ? bus_wdata[OVF_LSB +: NSRC] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovf <= '0;
    else      r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
  end

  always_comb begin
    w_status                   = '0;
    w_status[NSRC-1:0]         = r_pending;
    w_status[OVF_LSB +: NSRC]  = r_ovf;
  end
`else
  always_comb begin
    w_status           = '0;
    w_status[NSRC-1:0] = r_pending;
  end
`endif

  // Reads sample the registers as they were before the access edge.
  always_comb begin
    w_rdata_next = '0;
    case (bus_addr)
      AW'(REG_STATUS): w_rdata_next = w_status;
      AW'(REG_MASK):   w_rdata_next[NSRC-1:0] = r_mask;
      AW'(REG_MODE):   w_rdata_next[NSRC-1:0] = r_mode;
      default:         w_rdata_next = '0;  // CLEAR reads as zero
    endcase
  end

  // Only the low bits (and the overflow field when built) of the write data
  // carry meaning; the rest is intentionally ignored.
  assign w_unused_wdata = ^bus_wdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_d     <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_rdata   <= '0;
      r_int_out <= '0;
      r_int_any <= 1'b0;
      r_int_id  <= '0;
    end else begin
      r_s_d     <= w_s;
      r_pending <= w_pending_next;
      r_mask    <= w_mask_next;
      r_mode    <= w_mode_next;
      r_int_out <= w_int_next;
      r_int_any <= |w_int_next;
      r_int_id  <= w_id_next;
      if (w_rd) r_rdata <= w_rdata_next;
    end
  end

  assign bus_rdata = r_rdata;
  assign int_out   = r_int_out;
  assign int_any   = r_int_any;
  assign int_id    = r_int_id;

endmodule : irq_ctrl
